// File: rtl/divider_pkg.sv
// ----------------------------------------------------------------------------
// divider_pkg
// Shared types and constants for the sequential restoring divider.
//   state_t            : controller states (IDLE, RUN, DONE)
//   DEFAULT_DIVIDEND_W : default dividend / quotient width (and step count)
//   DEFAULT_DIVISOR_W  : default divisor / remainder width
//   cnt_width()        : width of the step counter, enough to hold DIVIDEND_W
// ----------------------------------------------------------------------------
package divider_pkg;

    localparam int DEFAULT_DIVIDEND_W = 8;
    localparam int DEFAULT_DIVISOR_W  = 4;
    localparam int DEFAULT_CNT_W      = $clog2(DEFAULT_DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage : divider_pkg

// File: rtl/divider_step.sv
// ----------------------------------------------------------------------------
// divider_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits.
//   i_rem     : partial remainder r[DIVISOR_W-1:0] before the step
//   i_bit     : next dividend bit (MSB first)
//   i_divisor : divisor
//   o_rem     : partial remainder after the step
//   o_q_bit   : quotient bit produced by this step
// The remainder is carried as DIVISOR_W bits: the MSB of the DIVISOR_W+1 bit
// partial remainder is always shifted out by the next step, so only the
// shifted value r' needs the extra bit, and only for the compare.
// ----------------------------------------------------------------------------
module divider_step
    import divider_pkg::*;
#(
    parameter int DIVISOR_W = DEFAULT_DIVISOR_W
) (
    input  logic [DIVISOR_W-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_rem,
    output logic                 o_q_bit
);

    logic [DIVISOR_W:0]   w_shift;
    logic [DIVISOR_W-1:0] w_diff;

    always_comb begin
        w_shift = {i_rem, i_bit};
        o_q_bit = (w_shift >= {1'b0, i_divisor});
        // When the divisor fits, r' - divisor < divisor, so the low bits of a
        // modular subtract are the whole answer. With a zero divisor the MSB
        // is dropped, which the next shift would discard anyway.
        w_diff  = w_shift[DIVISOR_W-1:0] - i_divisor;
        o_rem   = o_q_bit ? w_diff : w_shift[DIVISOR_W-1:0];
    end

endmodule : divider_step

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider: DIVIDEND_W-bit unsigned dividend divided by a
// DIVISOR_W-bit unsigned divisor, one quotient bit per clock, behind a
// start/busy/done handshake.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high reset
//   start       : request a division (ignored while busy)
//   dividend    : dividend, captured on an accepted start
//   divisor     : divisor, captured on an accepted start
//   busy        : high while iterating (RUN)
//   done        : one-cycle pulse when a new result is loaded
//   quotient    : last completed quotient
//   remainder   : last completed remainder
//   div_by_zero : last completed division had a zero divisor
//                 (only with DIVIDER_DBZ_EN)
// Build option: `define DIVIDER_DBZ_EN adds div_by_zero and short-circuits a
// zero divisor straight to DONE. Without it a zero divisor runs the normal
// algorithm, which yields quotient = all ones, remainder = dividend low bits.
// ----------------------------------------------------------------------------
module seq_divider
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEFAULT_DIVIDEND_W,
    parameter int DIVISOR_W  = DEFAULT_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
`ifdef DIVIDER_DBZ_EN
    ,
    output logic                  div_by_zero
`endif
);

    localparam int               CNT_W     = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;

    // Dividend bits shift out of the MSB while quotient bits shift into the
    // LSB, so after DIVIDEND_W steps this register holds the quotient.
    logic [DIVIDEND_W-1:0] r_dq;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_zero_skip;
    logic                  w_q_bit;
    logic [DIVISOR_W-1:0]  w_step_rem;

`ifdef DIVIDER_DBZ_EN
    logic                  r_dbz;
    assign w_zero_skip = (divisor == '0);
    assign div_by_zero = r_dbz;
`else
    assign w_zero_skip = 1'b0;
`endif

    assign w_accept  = start && (r_state != RUN);
    assign w_last    = (r_state == RUN) && (r_cnt == LAST_STEP);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

    divider_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dq[DIVIDEND_W-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_q_bit)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_skip ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt = w_zero_skip ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and the result registers that
    // only change on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dq        <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIVIDER_DBZ_EN
            r_dbz       <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_dq      <= dividend;
                r_divisor <= divisor;
                r_rem     <= '0;
                r_cnt     <= '0;
            end else if (r_state == RUN) begin
                r_dq  <= {r_dq[DIVIDEND_W-2:0], w_q_bit};
                r_rem <= w_step_rem;
                r_cnt <= r_cnt + CNT_ONE;
            end

            if (w_last) begin
                r_quotient  <= {r_dq[DIVIDEND_W-2:0], w_q_bit};
                r_remainder <= w_step_rem;
`ifdef DIVIDER_DBZ_EN
                r_dbz       <= 1'b0;
            end else if (w_accept && w_zero_skip) begin
                r_quotient  <= '1;
                r_remainder <= dividend[DIVISOR_W-1:0];
                r_dbz       <= 1'b1;
`endif
            end
        end
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (8 / 4 default widths). Expected results
// come from a reference model and are queued when a start is driven, then
// popped when done is observed. Latency is counted in clock edges after the
// accepting edge until done is visible. Honours DIVIDER_DBZ_EN if defined.
// ----------------------------------------------------------------------------
module tb_seq_divider;

    import divider_pkg::*;

`ifdef DIVIDER_DBZ_EN
    localparam int   ZERO_LAT = 0;
    localparam logic ZERO_DBZ = 1'b1;
`else
    localparam int   ZERO_LAT = 8;
    localparam logic ZERO_DBZ = 1'b0;
`endif

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
`ifdef DIVIDER_DBZ_EN
    logic       div_by_zero;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    seq_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
`ifdef DIVIDER_DBZ_EN
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`else
        .remainder   (remainder)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        if (b != 4'd0) begin
            e.q   = a / {4'd0, b};
            e.r   = 4'(a % {4'd0, b});
            e.dbz = 1'b0;
            e.lat = 8;
        end else begin
            e.q   = 8'hFF;
            e.r   = a[3:0];
            e.dbz = ZERO_DBZ;
            e.lat = ZERO_LAT;
        end
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic start_div(input logic [7:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; returns at the falling edge where done is seen.
    task automatic wait_done(output int lat, output int busy_n,
                             output bit overlap, output bit timeout);
        lat     = 0;
        busy_n  = 0;
        overlap = 1'b0;
        timeout = 1'b0;
        while (done !== 1'b1) begin
            if (busy === 1'b1) busy_n++;
            if (lat >= 20) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
        checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
`ifdef DIVIDER_DBZ_EN
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, busy_n; bit ov, to; exp_t e;
        start_div(8'd200, 4'd7);
        wait_done(lat, busy_n, ov, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: done not seen after %0d cycles", lat); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (busy_n != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", busy_n); end
        checks++; if (ov) begin errors++; $display("FAIL basic_busy_done_overlap: got 1 expected 0"); end
        checks++; if (quotient !== e.q) begin errors++; $display("FAIL basic_quotient: got %0d expected %0d", quotient, e.q); end
        checks++; if (remainder !== e.r) begin errors++; $display("FAIL basic_remainder: got %0d expected %0d", remainder, e.r); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_return_idle: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (quotient !== e.q) begin errors++; $display("FAIL basic_hold: got %0d expected %0d", quotient, e.q); end
    endtask

    task automatic test_edges();
        logic [7:0] a_tab [2] = '{8'd255, 8'd5};
        logic [3:0] b_tab [2] = '{4'd1, 4'd15};
        int lat, busy_n; bit ov, to; exp_t e;
        for (int i = 0; i < 2; i++) begin
            start_div(a_tab[i], b_tab[i]);
            wait_done(lat, busy_n, ov, to);
            e = sb.pop_front();
            checks++; if (to || lat != e.lat) begin errors++; $display("FAIL edge_latency %0d/%0d: got %0d expected %0d", a_tab[i], b_tab[i], lat, e.lat); end
            checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL edge_result %0d/%0d: got %0d r %0d expected %0d r %0d", a_tab[i], b_tab[i], quotient, remainder, e.q, e.r); end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        int lat, busy_n; bit ov, to; exp_t e;
        start_div(8'hA7, 4'd0);
        wait_done(lat, busy_n, ov, to);
        e = sb.pop_front();
        checks++; if (to || lat != e.lat) begin errors++; $display("FAIL dbz_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL dbz_quotient: got %0h expected ff", quotient); end
        checks++; if (remainder !== 4'd7) begin errors++; $display("FAIL dbz_remainder: got %0d expected 7", remainder); end
`ifdef DIVIDER_DBZ_EN
        checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL dbz_flag: got %b expected %b", div_by_zero, e.dbz); end
        @(negedge clk);
        start_div(8'd9, 4'd3);
        wait_done(lat, busy_n, ov, to);
        e = sb.pop_front();
        checks++; if (div_by_zero !== e.dbz || quotient !== e.q) begin errors++; $display("FAIL dbz_clear: got dbz=%b q=%0d expected dbz=%b q=%0d", div_by_zero, quotient, e.dbz, e.q); end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, busy_n; bit ov, to; exp_t e;
        start_div(8'd100, 4'd9);
        wait_done(lat, busy_n, ov, to);
        e = sb.pop_front();
        checks++; if (to || quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL b2b_first: got %0d r %0d expected %0d r %0d", quotient, remainder, e.q, e.r); end
        // start held in the DONE cycle
        start_div(8'd17, 4'd4);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got busy=%b done=%b expected 1 0", busy, done); end
        checks++; if (quotient !== 8'd11) begin errors++; $display("FAIL b2b_result_hold: got %0d expected 11", quotient); end
        // start pulse with different operands mid-RUN must be ignored
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'hFF;
        divisor  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_n, ov, to);
        e = sb.pop_front();
        checks++; if (to || lat + 3 != e.lat) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat + 3, e.lat); end
        checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL b2b_second: got %0d r %0d expected %0d r %0d", quotient, remainder, e.q, e.r); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_start: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int lat, busy_n; bit ov, to; exp_t e;
        start_div(8'd50, 4'd3);
        wait_done(lat, busy_n, ov, to);
        e = sb.pop_front();
        checks++; if (to || quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL abort_pre: got %0d r %0d expected %0d r %0d", quotient, remainder, e.q, e.r); end
        @(negedge clk);
        start_div(8'd90, 4'd7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        void'(sb.pop_back());
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (quotient !== 8'd0 || remainder !== 4'd0) begin errors++; $display("FAIL abort_results: got %0d r %0d expected 0 r 0", quotient, remainder); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_div(8'd90, 4'd7);
        wait_done(lat, busy_n, ov, to);
        e = sb.pop_front();
        checks++; if (to || lat != e.lat) begin errors++; $display("FAIL abort_post_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (quotient !== e.q || remainder !== e.r) begin errors++; $display("FAIL abort_post: got %0d r %0d expected %0d r %0d", quotient, remainder, e.q, e.r); end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int lat, busy_n; bit ov, to; exp_t e;
        logic [11:0] pair;
        for (int i = 0; i < 4096; i++) begin
            // odd multiplier gives a scrambled order that still covers every pair
            pair = 12'((i * 1597) % 4096);
            start_div(pair[11:4], pair[3:0]);
            wait_done(lat, busy_n, ov, to);
            e = sb.pop_front();
            checks++;
            if (to || ov || lat != e.lat || quotient !== e.q || remainder !== e.r) begin
                errors++;
                $display("FAIL sweep %0d/%0d: got %0d r %0d lat %0d expected %0d r %0d lat %0d",
                         pair[11:4], pair[3:0], quotient, remainder, lat, e.q, e.r, e.lat);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_divider
